// File: rtl/c2h_stream_arbiter.sv
// c2h_stream_arbiter
// Shares one C2H AXI-Stream output between NUM_SRC packet sources.
// Arbitration is round-robin and packet-atomic: once a source is granted it
// keeps the port until its tlast beat is accepted. The output is a single
// register stage, and every beat is tagged with the winning source index.
//
// Ports:
//   m_axis_c2h_aclk / m_axis_c2h_aresetn : clock, async active-low reset
//   s_axis_t{data,valid,last,ready}       : per-source input streams
//                                           (source i data at [i*W +: W])
//   src_enable                            : per-source arbitration mask
//   m_axis_c2h_t{data,keep,last,valid,ready,id} : output stream to the DMA
//   grant_idx : current or last granted source
//   busy      : high while a packet is being transferred (XFER)
//   pkt_count : number of completed output packets (wraps at 2^32)
module c2h_stream_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int ID_WIDTH        = 3
) (
  input  logic                               m_axis_c2h_aclk,
  input  logic                               m_axis_c2h_aresetn,
  input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]                 s_axis_tvalid,
  input  logic [NUM_SRC-1:0]                 s_axis_tlast,
  output logic [NUM_SRC-1:0]                 s_axis_tready,
  input  logic [NUM_SRC-1:0]                 src_enable,
  output logic [AXIS_DATA_WIDTH-1:0]         m_axis_c2h_tdata,
  output logic [63:0]                        m_axis_c2h_tkeep,
  output logic                               m_axis_c2h_tlast,
  output logic                               m_axis_c2h_tvalid,
  input  logic                               m_axis_c2h_tready,
  output logic [ID_WIDTH-1:0]                m_axis_c2h_tid,
  output logic [ID_WIDTH-1:0]                grant_idx,
  output logic                               busy,
  output logic [31:0]                        pkt_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t                     r_state;
  logic [ID_WIDTH-1:0]        r_rr_ptr;
  logic [ID_WIDTH-1:0]        r_grant_idx;
  logic                       r_tvalid;
  logic                       r_tlast;
  logic [ID_WIDTH-1:0]        r_tid;
  logic [AXIS_DATA_WIDTH-1:0] r_tdata;
  logic [31:0]                r_pkt_count;

  logic [NUM_SRC-1:0]         w_req;
  logic                       w_out_free;
  logic [NUM_SRC-1:0]         w_s_tready;
  logic                       w_found;
  logic [ID_WIDTH-1:0]        w_winner;
  logic [AXIS_DATA_WIDTH-1:0] w_sel_data;
  logic                       w_sel_last;
  logic                       w_accept;
  logic [ID_WIDTH-1:0]        w_next_ptr;

  assign w_req = s_axis_tvalid & src_enable;

  // The output register can take a new beat when empty or draining this cycle.
  assign w_out_free = !r_tvalid | m_axis_c2h_tready;

  // Ready depends only on registered state and the output handshake, never
  // on the source's own tvalid.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
      assign w_s_tready[gi] = (r_state == ST_XFER) &&
                              (r_grant_idx == ID_WIDTH'(gi)) && w_out_free;
    end
  endgenerate

  // Round-robin search: first requesting source at or above rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!w_found && w_req[i] && (((int'(r_rr_ptr) + k) % NUM_SRC) == i)) begin
          w_found  = 1'b1;
          w_winner = ID_WIDTH'(i);
        end
      end
    end
  end

  // Data/last mux for the granted source.
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant_idx == ID_WIDTH'(i)) begin
        w_sel_data = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        w_sel_last = s_axis_tlast[i];
      end
    end
  end

  // Only the granted source can have tready high, so any handshake is its.
  assign w_accept = |(s_axis_tvalid & w_s_tready);

  assign w_next_ptr = (r_grant_idx == ID_WIDTH'(NUM_SRC - 1)) ? '0
                                                              : r_grant_idx + ID_WIDTH'(1);

  // Arbitration FSM.
  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Runs even while the previous packet's last beat is still in the
          // output register, so the inter-packet gap is at most one cycle.
          if (w_found) begin
            r_grant_idx <= w_winner;
            r_state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_accept && w_sel_last) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register and packet counter.
  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tid       <= '0;
      r_tdata     <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_accept) begin
        r_tdata  <= w_sel_data;
        r_tlast  <= w_sel_last;
        r_tid    <= r_grant_idx;
        r_tvalid <= 1'b1;
      end else if (r_tvalid && m_axis_c2h_tready) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      if (r_tvalid && m_axis_c2h_tready && r_tlast) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
    end
  end

  assign s_axis_tready     = w_s_tready;
  assign m_axis_c2h_tdata  = r_tdata;
  assign m_axis_c2h_tkeep  = '1;
  assign m_axis_c2h_tlast  = r_tlast;
  assign m_axis_c2h_tvalid = r_tvalid;
  assign m_axis_c2h_tid    = r_tid;
  assign grant_idx         = r_grant_idx;
  assign busy              = (r_state == ST_XFER);
  assign pkt_count         = r_pkt_count;

endmodule

// File: tb/tb_c2h_stream_arbiter.sv
// Testbench for c2h_stream_arbiter: table of arbitration scenarios plus
// hand-written single-packet, enable-clear, backpressure and reset sequences.
// Accepted input beats are pushed to a scoreboard and popped on output
// handshakes; packet order is compared against hand-derived grant orders.
module tb_c2h_stream_arbiter;
  localparam int NS  = 4;
  localparam int W   = 512;
  localparam int IDW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS*W-1:0] s_tdata;
  logic [NS-1:0]   s_tvalid, s_tlast, s_tready, src_en;
  logic [W-1:0]    m_tdata;
  logic [63:0]     m_tkeep;
  logic            m_tlast, m_tvalid, m_tready;
  logic [IDW-1:0]  m_tid, grant;
  logic            busy;
  logic [31:0]     pkt_cnt;

  always #5 clk = ~clk;

  c2h_stream_arbiter #(.NUM_SRC(NS), .AXIS_DATA_WIDTH(W), .ID_WIDTH(IDW)) dut (
    .m_axis_c2h_aclk   (clk),
    .m_axis_c2h_aresetn(rst_n),
    .s_axis_tdata      (s_tdata),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tlast      (s_tlast),
    .s_axis_tready     (s_tready),
    .src_enable        (src_en),
    .m_axis_c2h_tdata  (m_tdata),
    .m_axis_c2h_tkeep  (m_tkeep),
    .m_axis_c2h_tlast  (m_tlast),
    .m_axis_c2h_tvalid (m_tvalid),
    .m_axis_c2h_tready (m_tready),
    .m_axis_c2h_tid    (m_tid),
    .grant_idx         (grant),
    .busy              (busy),
    .pkt_count         (pkt_cnt)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [W-1:0]   data;
    logic [IDW-1:0] tid;
    logic           last;
  } exp_t;

  // One arbitration scenario: sources in req each offer one packet of len beats.
  typedef struct packed {
    logic [3:0]       req;
    logic [3:0]       en;
    logic [3:0]       len;
    logic [2:0]       n;
    logic [3:0][2:0]  ord;
    logic [2:0]       grant;
  } vec_t;

  beat_t src_q [NS][$];
  exp_t  sb[$];
  int    pkt_tids[$];
  int    n_pass = 0;
  int    n_chk  = 0;
  int    in_beats = 0;
  int    out_beats = 0;
  int    cur_src = -1;
  int    tick_no = 0;
  int    first_out_tick = -1;
  logic  chk_no_src1 = 1'b0;
  vec_t  tab[6];

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic bit pending(logic [NS-1:0] mask);
    for (int i = 0; i < NS; i++)
      if (mask[i] && src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i]         = 1'b1;
        s_tdata[i*W +: W]   = src_q[i][0].data;
        s_tlast[i]          = src_q[i][0].last;
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tdata[i*W +: W]   = '0;
        s_tlast[i]          = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 ns later, then wait a cycle.
  task automatic tick();
    logic [NS-1:0] hs;
    exp_t e;
    drive();
    #1;
    hs = s_tvalid & s_tready;
    check("ready_onehot", W'($onehot0(s_tready)), W'(1));
    if (chk_no_src1) check("src1_ready", W'(s_tready[1]), W'(0));
    if (m_tvalid && m_tready) begin
      out_beats++;
      if (first_out_tick < 0) first_out_tick = tick_no;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL out_unexpected: got beat %0h expected none", m_tdata);
      end else begin
        e = sb.pop_front();
        check("out_data", m_tdata, e.data);
        check("out_tid", W'(m_tid), W'(e.tid));
        check("out_last", W'(m_tlast), W'(e.last));
        if (m_tlast) pkt_tids.push_back(int'(m_tid));
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        in_beats++;
        if (cur_src >= 0) check("no_interleave", W'(i), W'(cur_src));
        e.data = src_q[i][0].data;
        e.tid  = IDW'(i);
        e.last = src_q[i][0].last;
        sb.push_back(e);
        cur_src = e.last ? -1 : i;
        void'(src_q[i].pop_front());
      end
    end
    tick_no++;
    @(negedge clk);
  endtask

  task automatic drain(int max, logic [NS-1:0] mask, string name);
    int n;
    n = 0;
    while (n < max && (pending(mask) || sb.size() > 0)) begin
      tick();
      n++;
    end
    if (n >= max) begin
      n_chk++;
      $display("FAIL %s_timeout: got %0d cycles expected under %0d", name, n, max);
    end
  endtask

  task automatic load(int s, int len, int tag);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.data = W'(tag * 256 + s * 16 + j);
      b.data[W-1 -: 8] = 8'(8'h5A ^ tag);
      b.last = (j == len - 1);
      src_q[s].push_back(b);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NS; i++) src_q[i].delete();
    sb.delete();
    cur_src = -1;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_tvalid"}, W'(m_tvalid), W'(0));
    check({tag, "_tlast"}, W'(m_tlast), W'(0));
    check({tag, "_tid"}, W'(m_tid), W'(0));
    check({tag, "_tdata"}, m_tdata, W'(0));
    check({tag, "_s_tready"}, W'(s_tready), W'(0));
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_pkt_count"}, W'(pkt_cnt), W'(0));
    check({tag, "_grant"}, W'(grant), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_in, base_out, n;
    logic [W-1:0] hold_d;
    logic [IDW-1:0] hold_id;
    logic hold_l;
    logic [31:0] p0;
    beat_t b;

    tab[0] = '{req: 4'b0110, en: 4'b1111, len: 4'd2, n: 3'd2, ord: {3'd0, 3'd0, 3'd2, 3'd1}, grant: 3'd2};
    tab[1] = '{req: 4'b1001, en: 4'b1111, len: 4'd2, n: 3'd2, ord: {3'd0, 3'd0, 3'd0, 3'd3}, grant: 3'd0};
    tab[2] = '{req: 4'b0011, en: 4'b1111, len: 4'd1, n: 3'd2, ord: {3'd0, 3'd0, 3'd0, 3'd1}, grant: 3'd0};
    tab[3] = '{req: 4'b1111, en: 4'b1101, len: 4'd2, n: 3'd3, ord: {3'd0, 3'd0, 3'd3, 3'd2}, grant: 3'd0};
    tab[4] = '{req: 4'b1100, en: 4'b1111, len: 4'd3, n: 3'd2, ord: {3'd0, 3'd0, 3'd3, 3'd2}, grant: 3'd3};
    tab[5] = '{req: 4'b0001, en: 4'b1111, len: 4'd1, n: 3'd1, ord: {3'd0, 3'd0, 3'd0, 3'd0}, grant: 3'd0};

    rst_n = 1'b0;
    m_tready = 1'b1;
    src_en = '1;
    s_tvalid = '0;
    s_tlast = '0;
    s_tdata = '0;
    #1;
    check_reset_vals("reset");
    check("tkeep", W'(m_tkeep), W'(64'hFFFF_FFFF_FFFF_FFFF));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 3-beat packet from source 0.
    tick_no = 0;
    first_out_tick = -1;
    pkt_tids.delete();
    for (int j = 0; j < 3; j++) begin
      b.data = W'(8'hA1 + j);
      b.last = (j == 2);
      src_q[0].push_back(b);
    end
    drain(50, 4'b0001, "single");
    check("single_latency", W'(first_out_tick), W'(2));
    check("single_pkt_count", W'(pkt_cnt), W'(1));
    check("single_out_beats", W'(out_beats), W'(3));
    check("single_pkts", W'(pkt_tids.size()), W'(1));
    if (pkt_tids.size() > 0) check("single_tid", W'(pkt_tids[0]), W'(0));
    $display("single: out_beats=%0d pkt_count=%0d latency=%0d", out_beats, pkt_cnt, first_out_tick);

    // Table of arbitration scenarios, starting from rr_ptr=0.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      pkt_tids.delete();
      p0 = pkt_cnt;
      src_en = tab[k].en;
      chk_no_src1 = !tab[k].en[1];
      for (int i = 0; i < NS; i++)
        if (tab[k].req[i]) load(i, int'(tab[k].len), k);
      drain(200, tab[k].req & tab[k].en, "table");
      chk_no_src1 = 1'b0;
      flush();
      check("table_npkts", W'(pkt_tids.size()), W'(tab[k].n));
      for (int j = 0; j < int'(tab[k].n); j++) begin
        if (j < pkt_tids.size()) check("table_order", W'(pkt_tids[j]), W'(tab[k].ord[j]));
      end
      check("table_grant", W'(grant), W'(tab[k].grant));
      check("table_pkt_count", W'(pkt_cnt - p0), W'(tab[k].n));
      $display("table[%0d]: req=%b en=%b pkts=%0d grant=%0d", k, tab[k].req, tab[k].en, pkt_tids.size(), grant);
    end
    src_en = '1;

    // Clearing the granted source's enable mid-packet lets the packet finish.
    pkt_tids.delete();
    base_in = in_beats;
    base_out = out_beats;
    load(2, 4, 9);
    n = 0;
    while (in_beats == base_in && n < 20) begin tick(); n++; end
    src_en = '0;
    drain(50, 4'b0100, "en_clear");
    check("en_clear_beats", W'(out_beats - base_out), W'(4));
    check("en_clear_pkts", W'(pkt_tids.size()), W'(1));
    if (pkt_tids.size() > 0) check("en_clear_tid", W'(pkt_tids[0]), W'(2));
    $display("en_clear: out=%0d busy=%0d", out_beats - base_out, busy);
    src_en = '1;

    // Backpressure: 5 stalled cycles mid-packet.
    base_in = in_beats;
    base_out = out_beats;
    load(0, 6, 10);
    n = 0;
    while (out_beats - base_out < 2 && n < 20) begin tick(); n++; end
    m_tready = 1'b0;
    #1;
    hold_d = m_tdata;
    hold_id = m_tid;
    hold_l = m_tlast;
    check("bp_valid", W'(m_tvalid), W'(1));
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      check("bp_tdata", m_tdata, hold_d);
      check("bp_tid", W'(m_tid), W'(hold_id));
      check("bp_tlast", W'(m_tlast), W'(hold_l));
      check("bp_s_tready", W'(s_tready), W'(0));
    end
    m_tready = 1'b1;
    drain(50, 4'b0001, "bp");
    check("bp_in_beats", W'(in_beats - base_in), W'(6));
    check("bp_out_beats", W'(out_beats - base_out), W'(6));
    $display("backpressure: in=%0d out=%0d", in_beats - base_in, out_beats - base_out);

    // Reset during beat 2 of 4: outputs clear without a clock edge.
    base_in = in_beats;
    load(0, 4, 11);
    n = 0;
    while (in_beats - base_in < 2 && n < 20) begin tick(); n++; end
    check("pre_reset_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pkt_tids.delete();
    load(0, 3, 12);
    drain(50, 4'b0001, "post_reset");
    check("post_reset_pkt_count", W'(pkt_cnt), W'(1));
    check("post_reset_pkts", W'(pkt_tids.size()), W'(1));
    $display("reset_mid_packet: pkt_count=%0d", pkt_cnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/c2h_stream_arbiter.md
Name: c2h_stream_arbiter

Overview:
- Shares the single 512-bit C2H AXI-Stream port of the host DMA between up to NUM_SRC packet sources, e.g. several trace packagers or a packager plus a status/log source.
- Arbitration is round-robin and packet-atomic: a granted source keeps the port until its tlast beat is accepted.
- The output is registered and the winning source index is tagged on every beat.
- Sits between the packet sources and the DMA C2H channel, in the m_axis_c2h_aclk domain.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- AXIS_DATA_WIDTH, 512, stream data width in bits.
- ID_WIDTH, 3, width of the source-index tag; must be at least clog2(NUM_SRC).

Ports:
- m_axis_c2h_aclk  in  1  single clock for the whole block
- m_axis_c2h_aresetn  in  1  reset; asynchronous assert, active-low
- s_axis_tdata  in  NUM_SRC*AXIS_DATA_WIDTH  source data, source i at slice [i*W +: W]
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tlast  in  NUM_SRC  per-source last beat of packet
- s_axis_tready  out  NUM_SRC  per-source ready
- src_enable  in  NUM_SRC  per-source arbitration enable mask
- m_axis_c2h_tdata  out  AXIS_DATA_WIDTH  output data
- m_axis_c2h_tkeep  out  64  constant all-ones
- m_axis_c2h_tlast  out  1  output last
- m_axis_c2h_tvalid  out  1  output valid
- m_axis_c2h_tready  in  1  DMA ready
- m_axis_c2h_tid  out  ID_WIDTH  source index of the current output beat
- grant_idx  out  ID_WIDTH  currently or last granted source
- busy  out  1  high in XFER
- pkt_count  out  32  count of output packets completed (tlast handshakes)

Behaviour:
- Clock and reset: one clock, m_axis_c2h_aclk. Reset is asynchronous and active-low on m_axis_c2h_aresetn.
- Reset values:
  - state=IDLE; rr_ptr=0; grant_idx=0.
  - m_axis_c2h_tvalid=0, tlast=0, tid=0, tdata=0.
  - s_axis_tready=0; busy=0; pkt_count=0.
- A reset mid-packet discards the packet in flight. No recovery of a partial packet is attempted.
- State machine:
  - IDLE → XFER:
    - req = s_axis_tvalid & src_enable.
    - When req is nonzero, grant the first set bit searching from rr_ptr upward, wrapping modulo NUM_SRC.
    - Register the winner in grant_idx and go to XFER. Arbitration latency is one cycle.
    - When req is zero, stay in IDLE.
  - XFER:
    - s_axis_tready[grant_idx] = !m_axis_c2h_tvalid | m_axis_c2h_tready. All other tready bits are 0.
    - tready is combinational from registered state and the output handshake only; it never depends on s_axis_tvalid.
  - XFER → IDLE:
    - Occurs on an accepted input beat, i.e. s_axis_tvalid[g] & s_axis_tready[g], that has s_axis_tlast[g]=1.
    - On that beat, rr_ptr <= (g+1) mod NUM_SRC.
- Output register:
  - On an accepted input beat, load tdata, tlast and tid=g, and set tvalid=1.
  - Otherwise, on m_axis_c2h_tvalid & m_axis_c2h_tready, clear tvalid (and tlast).
  - While tvalid=1 and tready=0, tdata, tlast and tid hold stable.
  - Throughput is one beat per cycle while tready=1.
- Overlap: IDLE arbitration proceeds while the last beat of the previous packet is still in the output register. The next packet's first beat is accepted only when the register frees or drains in the same cycle. Worst-case inter-packet gap is one cycle.
- pkt_count increments by 1 on every output handshake with tlast=1 and wraps at 2^32.
- src_enable:
  - Sampled only in IDLE.
  - Deasserting it for the granted source mid-packet does not abort or stall that packet.
  - A disabled source's tready stays 0.
- NUM_SRC=1 degenerates to a pass-through register with the same one-cycle arbitration bubble.
- Packets are never interleaved. Beats from a non-granted source are never accepted.
- Protocol violations (tvalid deasserting before handshake) are not checked; data is forwarded as presented.

Test Plan:
- Single packet: source 0 sends a 3-beat packet, tdata 0xA1/0xA2/0xA3, tready=1.
  - Output shows the same 3 beats with tid=0 and tlast on beat 3.
  - First output beat appears 2 cycles after s_axis_tvalid rises.
  - pkt_count=1.
- Contention: sources 1 and 2 each hold a 2-beat packet at the same time, starting with rr_ptr=0.
  - Order is src1 then src2, never interleaved.
  - rr_ptr ends at 3; pkt_count=2.
- Wrap: rr_ptr=3 and sources 0 and 3 both request.
  - Source 3 wins, then source 0; rr_ptr ends at 1.
- Backpressure: hold m_axis_c2h_tready=0 for 5 cycles mid-packet.
  - tdata, tid and tlast stay stable.
  - s_axis_tready[g]=0 throughout.
  - No beat is lost or duplicated; the beat count out equals the beat count in.
- Enable mask: src_enable=4'b1101 with all sources requesting.
  - Source 1 is never granted and its tready stays 0.
  - Clearing src_enable[g] mid-packet lets that packet complete.
- Reset mid-packet: assert m_axis_c2h_aresetn low during beat 2 of 4.
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - After release, a fresh packet from source 0 is transferred cleanly with pkt_count=1.
